// File: rtl/iomem_led_pwm.sv
// Eight-channel LED PWM controller on the picosoc iomem bus.
// Shadow duties are copied to the active set at each period wrap, so a duty change never glitches a cycle.
module iomem_led_pwm #(
    parameter logic [7:0]  ADDR_HI      = 8'h04,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [7:0]  pwm_out,
    output logic        period_irq
);

    localparam logic [7:0] OFF_CTRL  = 8'h00;
    localparam logic [7:0] OFF_PRE   = 8'h04;
    localparam logic [7:0] OFF_COUNT = 8'h08;
    localparam logic [7:0] OFF_DUTY0 = 8'h10;
    localparam logic [7:0] OFF_DUTY1 = 8'h14;

    logic [2:0]       ctrl_q, ctrl_next;
    logic [15:0]      prescale_q, prescale_next;
    logic [7:0][7:0]  shadow_q, shadow_next;
    logic [7:0][7:0]  active_q;
    logic [15:0]      pre_cnt;
    logic [7:0]       pwm_cnt;
    logic [7:0]       off;
    logic [31:0]      rd_val;
    logic             sel, wr, run, tick, wrap;
    logic             unused_addr;

    // Handshake: a request is taken when valid is high, ready is low and the
    // window matches; ready then pulses for exactly one cycle with rdata holding
    // the pre-write register value. Requests outside the window are never acked.
    assign sel  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
    assign wr   = sel && (iomem_wstrb != 4'b0000);
    assign off  = iomem_addr[7:0];
    assign unused_addr = ^iomem_addr[23:8];

    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_CTRL:  rd_val = {29'b0, ctrl_q};
            OFF_PRE:   rd_val = {16'b0, prescale_q};
            OFF_COUNT: rd_val = {16'b0, pre_cnt[7:0], pwm_cnt};
            OFF_DUTY0: rd_val = shadow_q[3:0];
            OFF_DUTY1: rd_val = shadow_q[7:4];
            default:   rd_val = 32'h0;
        endcase
    end

    always_comb begin
        ctrl_next     = ctrl_q;
        prescale_next = prescale_q;
        shadow_next   = shadow_q;
        if (wr) begin
            case (off)
                OFF_CTRL: begin
                    if (iomem_wstrb[0]) ctrl_next = iomem_wdata[2:0];
                end
                OFF_PRE: begin
                    if (iomem_wstrb[0]) prescale_next[7:0]  = iomem_wdata[7:0];
                    if (iomem_wstrb[1]) prescale_next[15:8] = iomem_wdata[15:8];
                end
                OFF_DUTY0: begin
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) shadow_next[b] = iomem_wdata[8*b +: 8];
                end
                OFF_DUTY1: begin
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) shadow_next[4+b] = iomem_wdata[8*b +: 8];
                end
                default: ;
            endcase
        end
    end

    // A write clearing EN on this edge takes priority over counting and wrap.
    assign run  = ctrl_q[0] && ctrl_next[0];
    assign tick = (pre_cnt == prescale_q);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            ctrl_q      <= 3'b000;
            prescale_q  <= PRESCALE_RST;
            shadow_q    <= '0;
            active_q    <= '0;
            pre_cnt     <= 16'h0;
            pwm_cnt     <= 8'h0;
            pwm_out     <= 8'h0;
            period_irq  <= 1'b0;
        end else begin
            iomem_ready <= sel;
            if (sel) iomem_rdata <= rd_val;
            ctrl_q     <= ctrl_next;
            prescale_q <= prescale_next;
            shadow_q   <= shadow_next;
            if (run) begin
                if (tick) begin
                    pre_cnt <= 16'h0;
                    pwm_cnt <= pwm_cnt + 8'd1;
                end else begin
                    pre_cnt <= pre_cnt + 16'd1;
                end
                if (wrap) active_q <= shadow_q;
                period_irq <= wrap && ctrl_q[2];
                for (int i = 0; i < 8; i++)
                    pwm_out[i] <= (pwm_cnt < active_q[i]) ^ ctrl_q[1];
            end else begin
                pre_cnt    <= 16'h0;
                pwm_cnt    <= 8'h0;
                active_q   <= shadow_q;
                period_irq <= 1'b0;
                pwm_out    <= {8{ctrl_q[1]}};
            end
        end
    end

endmodule

// File: tb/tb_iomem_led_pwm.sv
// Bench for iomem_led_pwm: register vectors, closed-form PWM timing model, random trials.
module tb_iomem_led_pwm;

    localparam logic [7:0] ADDR_HI = 8'h04;
    localparam logic [31:0] BASE   = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [7:0]  pwm_out;
    logic        period_irq;

    iomem_led_pwm #(.ADDR_HI(ADDR_HI), .PRESCALE_RST(16'd0)) dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .pwm_out(pwm_out), .period_irq(period_irq)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // driver: called just after a falling edge, returns just after a falling edge
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r, output int acc);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        @(negedge clk);
        acc = cyc;
        chk("ready_high", {31'b0, iomem_ready}, 32'd1);
        r = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        chk("ready_one_cycle", {31'b0, iomem_ready}, 32'd0);
    endtask

    // PWM timing model: n = clock edges since the enabling write edge
    bit          mon_on = 1'b0;
    int          e0, mp, w, off_n;
    bit          minv, mirq;
    logic [7:0]  dold[8];
    logic [7:0]  dnew[8];
    int          mn, mm, mstep;
    logic [7:0]  ep;
    logic        eirq;
    logic [7:0]  dsel;

    always @(negedge clk) begin
        if (mon_on) begin
            mn = cyc - e0;
            if (mn >= 1) begin
                mm = mn - 1;
                mstep = (mm / (mp + 1)) % 256;
                for (int i = 0; i < 8; i++) begin
                    dsel = (mm >= w) ? dnew[i] : dold[i];
                    ep[i] = (mstep < int'(dsel)) ^ minv;
                end
                if (mn > off_n) ep = 8'h00;
                else if (mn == off_n) ep = {8{minv}};
                eirq = mirq && (mn % (mp + 1) == 0) && ((mn / (mp + 1)) % 256 == 0) && (mn < off_n);
                chk("pwm_out", {24'b0, pwm_out}, {24'b0, ep});
                chk("period_irq", {31'b0, period_irq}, {31'b0, eirq});
            end
        end
    end

    task automatic wait_n(input int target);
        while (cyc - e0 < target) @(negedge clk);
    endtask

    task automatic trial(input int p, input logic [63:0] duties, input bit inv, input bit irqen,
                         input bit midw, input bit offw);
        logic [31:0] r;
        logic [63:0] nd;
        int acc, per, nw, m;
        logic [31:0] ecount;
        mon_on = 1'b0;
        bus(BASE + 32'h00, 4'hF, 32'h0, r, acc);
        bus(BASE + 32'h04, 4'hF, p, r, acc);
        bus(BASE + 32'h10, 4'hF, duties[31:0], r, acc);
        bus(BASE + 32'h14, 4'hF, duties[63:32], r, acc);
        for (int i = 0; i < 8; i++) begin
            dold[i] = duties[8*i +: 8];
            dnew[i] = dold[i];
        end
        w = 1 << 30;
        off_n = 1 << 30;
        mp = p;
        minv = inv;
        mirq = irqen;
        per = 256 * (p + 1);
        bus(BASE + 32'h00, 4'h1, {29'b0, irqen, inv, 1'b1}, r, acc);
        e0 = acc;
        mon_on = 1'b1;
        if (midw) begin
            nw = $urandom_range(5, per - 20);
            wait_n(nw);
            nd = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) dnew[i] = nd[8*i +: 8];
            w = ((cyc - e0 + 1) / per + 1) * per;
            bus(BASE + 32'h10, 4'hF, nd[31:0], r, acc);
            bus(BASE + 32'h14, 4'hF, nd[63:32], r, acc);
        end
        if (offw) begin
            wait_n(2 * per - 1);
            chk("wrap_align", cyc - e0, 2 * per - 1);
            off_n = 2 * per;
            bus(BASE + 32'h00, 4'h1, 32'h0, r, acc);
            wait_n(2 * per + 20);
        end else begin
            wait_n(per + 300);
        end
        bus(BASE + 32'h08, 4'h0, 32'h0, r, acc);
        m = acc - 1 - e0;
        if (m >= off_n) ecount = 32'h0;
        else ecount = {16'b0, 8'(m % (p + 1)), 8'((m / (p + 1)) % 256)};
        chk("count_reg", r, ecount);
        mon_on = 1'b0;
        bus(BASE + 32'h00, 4'hF, 32'h0, r, acc);
    endtask

    // register-level model for the random access test
    logic [2:0]  r_ctrl;
    logic [15:0] r_pre;
    logic [63:0] r_duty;
    logic [7:0]  offs[8] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h0C, 8'h18, 8'h40, 8'hFC};

    function automatic logic [31:0] model_read(input logic [7:0] o);
        case (o)
            8'h00:   return {29'b0, r_ctrl};
            8'h04:   return {16'b0, r_pre};
            8'h10:   return r_duty[31:0];
            8'h14:   return r_duty[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] o, input logic [3:0] s, input logic [31:0] d);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                if (o == 8'h00 && b == 0) r_ctrl = d[2:0];
                if (o == 8'h04 && b < 2) r_pre[8*b +: 8] = d[8*b +: 8];
                if (o == 8'h10) r_duty[8*b +: 8] = d[8*b +: 8];
                if (o == 8'h14) r_duty[32 + 8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    initial begin
        logic [31:0] r;
        logic [31:0] last_r;
        logic [63:0] rd;
        logic [7:0]  o;
        logic [3:0]  s;
        logic [31:0] d;
        int acc;

        vecs[0]  = '{BASE + 32'h00, 4'h0, 32'h0, 32'h0};
        vecs[1]  = '{BASE + 32'h04, 4'h0, 32'h0, 32'h0};
        vecs[2]  = '{BASE + 32'h08, 4'h0, 32'h0, 32'h0};
        vecs[3]  = '{BASE + 32'h10, 4'h0, 32'h0, 32'h0};
        vecs[4]  = '{BASE + 32'h14, 4'h0, 32'h0, 32'h0};
        vecs[5]  = '{BASE + 32'h10, 4'b0101, 32'h40FF0080, 32'h0};
        vecs[6]  = '{BASE + 32'h10, 4'h0, 32'h0, 32'h00FF0080};
        vecs[7]  = '{BASE + 32'h14, 4'hF, 32'h12345678, 32'h0};
        vecs[8]  = '{32'h04ABCD14, 4'h0, 32'h0, 32'h12345678};
        vecs[9]  = '{BASE + 32'h08, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{BASE + 32'h08, 4'h0, 32'h0, 32'h0};
        vecs[11] = '{BASE + 32'h00, 4'hF, 32'hFFFFFFF8, 32'h0};
        vecs[12] = '{BASE + 32'h00, 4'h0, 32'h0, 32'h0};
        vecs[13] = '{BASE + 32'h04, 4'b1100, 32'hFFFF0000, 32'h0};
        vecs[14] = '{BASE + 32'h0C, 4'hF, 32'h0000DEAD, 32'h0};
        vecs[15] = '{BASE + 32'h0C, 4'h0, 32'h0, 32'h0};
        vecs[16] = '{BASE + 32'h04, 4'b0011, 32'h00012345, 32'h0};
        vecs[17] = '{BASE + 32'h04, 4'hF, 32'h0, 32'h00002345};

        // reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, iomem_ready}, 32'd0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_pwm", {24'b0, pwm_out}, 32'h0);
        chk("rst_irq", {31'b0, period_irq}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // register vectors
        for (int k = 0; k < 18; k++) begin
            bus(vecs[k].addr, vecs[k].wstrb, vecs[k].wdata, r, acc);
            chk($sformatf("vec%0d", k), r, vecs[k].exp);
        end
        last_r = vecs[17].exp;

        // outside the window: no ack, rdata held, no register change
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("outside_ready", {31'b0, iomem_ready}, 32'd0);
            chk("outside_rdata", iomem_rdata, last_r);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        bus(BASE + 32'h00, 4'h0, 32'h0, r, acc);
        chk("outside_no_write", r, 32'h0);

        // directed PWM trials
        trial(0, 64'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        trial(0, 64'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        bus(BASE + 32'h00, 4'hF, 32'h2, r, acc);
        chk("disabled_inv_pwm", {24'b0, pwm_out}, 32'hFF);
        chk("disabled_irq", {31'b0, period_irq}, 32'd0);
        bus(BASE + 32'h08, 4'h0, 32'h0, r, acc);
        chk("disabled_count", r, 32'h0);
        trial(3, 64'h40, 1'b0, 1'b1, 1'b1, 1'b0);
        trial(0, 64'hFF00_80C0_01FF_0040, 1'b0, 1'b1, 1'b0, 1'b1);

        // randomized trials
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0: rd[8*i +: 8] = 8'h00;
                    1: rd[8*i +: 8] = 8'hFF;
                    default: rd[8*i +: 8] = 8'($urandom_range(0, 255));
                endcase
            end
            trial($urandom_range(0, 2), rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        // random register accesses against the register model
        bus(BASE + 32'h04, 4'hF, 32'h0, r, acc);
        bus(BASE + 32'h10, 4'hF, 32'h0, r, acc);
        bus(BASE + 32'h14, 4'hF, 32'h0, r, acc);
        r_ctrl = 3'b0;
        r_pre  = 16'h0;
        r_duty = 64'h0;
        for (int k = 0; k < 40; k++) begin
            o = offs[$urandom_range(0, 7)];
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            exp_q.push_back(model_read(o));
            model_write(o, s, d);
            bus({ADDR_HI, 16'($urandom), o}, s, d, r, acc);
            chk("reg_random", r, exp_q.pop_front());
        end
        bus(BASE + 32'h00, 4'hF, 32'h2, r, acc);
        bus(BASE + 32'h10, 4'hF, 32'hA5A5A5A5, r, acc);
        chk("pre_reset_pwm", {24'b0, pwm_out}, 32'hFF);

        // reset in the middle of an acknowledged access
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h10;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, iomem_ready}, 32'd0);
        chk("midrst_rdata", iomem_rdata, 32'h0);
        chk("midrst_pwm", {24'b0, pwm_out}, 32'h0);
        chk("midrst_irq", {31'b0, period_irq}, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus(BASE + 32'h00, 4'h0, 32'h0, r, acc);
        chk("after_rst_ctrl", r, 32'h0);
        bus(BASE + 32'h10, 4'h0, 32'h0, r, acc);
        chk("after_rst_duty0", r, 32'h0);
        bus(BASE + 32'h04, 4'h0, 32'h0, r, acc);
        chk("after_rst_prescale", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iomem_led_pwm.md
Name: iomem_led_pwm

Overview:
Memory-mapped 8-channel LED PWM controller on the picosoc iomem bus. It sits downstream of the SoC's iomem port, beside the board-level GPIO register. It decodes its own 16 MB window and produces glitch-free, brightness-controlled LED drive. It also produces a per-period interrupt pulse suitable for an irq_5..irq_7 input.

Parameters:
ADDR_HI, 8'h04, value of iomem_addr[31:24] selecting this block's window.
PRESCALE_RST, 16'd0, reset value of the PRESCALE register.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
iomem_valid  input  1  bus request valid
iomem_ready  output  1  one-cycle transaction acknowledge
iomem_wstrb  input  4  byte write strobes; 0 = read
iomem_addr  input  32  byte address
iomem_wdata  input  32  write data
iomem_rdata  output  32  read data, valid while iomem_ready=1
pwm_out  output  8  LED drive, bit i = channel i
period_irq  output  1  one-cycle pulse at PWM period wrap

Behaviour:
Reset (async, resetn=0):
- iomem_ready=0, iomem_rdata=0, pwm_out=0, period_irq=0.
- CTRL=0, PRESCALE=PRESCALE_RST, all shadow and active duties=0, pre_cnt=0, pwm_cnt=0.
- Reset mid-transaction aborts it; the request must be re-issued after release.

Register map (offset = iomem_addr[7:0]; addr[23:8] ignored):
- 0x00 CTRL: bit0 EN, bit1 INV, bit2 IRQ_EN; other bits read 0.
- 0x04 PRESCALE: [15:0]; upper bits read 0.
- 0x08 COUNT: read-only, {16'b0, pre_cnt[7:0], pwm_cnt}; writes ignored.
- 0x10 DUTY0: shadow duties ch3..ch0, byte n = channel n.
- 0x14 DUTY1: shadow duties ch7..ch4, byte n = channel 4+n.
- Any other offset inside the window: reads return 0, writes are ignored, and the access is still acknowledged.

Bus handshake:
- A transaction is accepted on the cycle where iomem_valid=1, iomem_ready=0 and addr[31:24]=ADDR_HI.
- iomem_ready=1 exactly on the next cycle, for one cycle.
- iomem_rdata is loaded on the same edge with the pre-write register value.
- Writes honour each wstrb bit per byte; unstrobed bytes are unchanged.
- Outside the window, iomem_ready stays 0 and iomem_rdata holds its value.
- Back-to-back accesses therefore take 2 cycles each.

Counters (EN=1):
- Each clk: if pre_cnt==PRESCALE, then pre_cnt<=0 and tick=1; else pre_cnt<=pre_cnt+1.
- PRESCALE=0 gives a tick every cycle.
- On tick, pwm_cnt<=pwm_cnt+1 (8-bit, 255 wraps to 0).
- On a tick with pwm_cnt==255 (period wrap):
  - all active duties <= shadow duties;
  - period_irq=1 for that one following cycle if IRQ_EN=1.
- Period = 256*(PRESCALE+1) clk cycles.
- A write to PRESCALE takes effect immediately. If the new PRESCALE is less than pre_cnt, the counter continues to 0xFFFF, wraps to 0, and then matches normally. No reset of pre_cnt occurs.

Output (registered, 1-cycle latency after the count):
- pwm_out[i] <= (pwm_cnt < active_duty[i]) XOR INV.
- Duty 0 gives constant 0; duty 255 gives high for 255 of 256 steps.

Disable (EN=0):
- pre_cnt and pwm_cnt are held at 0.
- Active duties track shadow duties every cycle.
- pwm_out <= {8{INV}}; period_irq=0.
- On EN 0->1, counting starts from 0 the next cycle using the current duties.

Simultaneous events:
- A DUTY write on the same edge as a period wrap: the active duty takes the old shadow, and the new value applies at the next wrap.
- A CTRL write that clears EN on a wrap edge: the disable wins, so no irq pulse.

Test Plan:
- Reset released, read 0x04000000/04/08/10/14 -> rdata 0, 0x0, 0, 0, 0; each ready exactly 1 cycle after valid.
- Write 0x04000010 = 0x40FF0080 with wstrb=4'b0101, then read it back -> 0x00FF0080 before the write (only bytes 0 and 2 written), i.e. readback 0x00FF0080.
- PRESCALE=0, DUTY0=0x00000040, CTRL=1 -> after the first wrap, pwm_out[0] is high 64 of every 256 cycles; ch1..3 stay 0; period 256 cycles.
- Same setup with CTRL=3 (INV) -> pwm_out[0] low 64/256 cycles; ch7..1 constant 1. With CTRL=2 (disabled) -> pwm_out=8'hFF.
- PRESCALE=3, CTRL=5 -> period_irq pulses once every 1024 cycles. Write DUTY0 mid-period -> pwm_out[0] unchanged until the next period_irq edge.
- Read 0x03000000 (outside window) -> iomem_ready stays 0. Assert resetn=0 mid-access -> ready, pwm_out and irq go 0 immediately; registers read 0 after release.
